// File: rtl/reset_seq_pkg.sv
// -----------------------------------------------------------------------------
// reset_seq_pkg
//   Shared types and width helpers for the reset sequencer.
//   - state_e       : sequencer state encoding (HOLD, RELEASE, DONE)
//   - clog2 / max2  : elaboration-time helpers used to size the hold/gap
//                     counter and the o_stage output
// -----------------------------------------------------------------------------
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // Smallest r such that 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter must be able to hold the larger of the two terminal counts.
  function automatic int counter_width(input int reset_cycles, input int stage_gap);
    return clog2(max2(reset_cycles, stage_gap) + 1);
  endfunction

  // o_stage counts 0..N_CH released channels.
  function automatic int stage_width(input int n_ch);
    return clog2(n_ch + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Generic two-flop synchroniser for a single asynchronous level input.
//   Adds two cycles of latency. Both flops clear to 0 on i_rst so the
//   synchronised value is well defined straight after a sequencer reset.
//
// Ports
//   i_clk : destination clock
//   i_rst : synchronous, active-high reset
//   i_d   : asynchronous input level
//   o_q   : synchronised output level
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/reset_seq.sv
// -----------------------------------------------------------------------------
// reset_seq
//   Power-on / soft reset sequencer. Holds N_CH active-low resets low for
//   RESET_CYCLES qualifying cycles after the clock source reports lock, then
//   releases them one at a time, STAGE_GAP cycles apart, lowest index first.
//   Loss of lock or a soft-reset request re-asserts every channel at once and
//   restarts the whole sequence.
//
// Parameters
//   RESET_CYCLES : initial hold length after lock (>= 1)
//   STAGE_GAP    : cycles between consecutive releases (0 = all together)
//   N_CH         : number of reset channels (>= 1)
//   SYNC_IN      : 1 = pass i_lock / i_rst_req through sync_2ff
//
// Ports
//   i_clk      : sequencer clock
//   i_rst      : synchronous, active-high reset of the sequencer
//   i_lock     : clock source locked
//   i_rst_req  : soft-reset request level, active-high
//   o_rstn     : per-channel active-low resets, bit 0 released first
//   o_rst_done : high once every channel is released
//   o_stage    : number of channels currently released
// -----------------------------------------------------------------------------
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int RESET_CYCLES = 100000,
  parameter int STAGE_GAP    = 1000,
  parameter int N_CH         = 4,
  parameter int SYNC_IN      = 1
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_lock,
  input  logic                              i_rst_req,
  output logic [N_CH-1:0]                   o_rstn,
  output logic                              o_rst_done,
  output logic [stage_width(N_CH)-1:0]      o_stage
);

  localparam int CW = counter_width(RESET_CYCLES, STAGE_GAP);
  localparam int SW = stage_width(N_CH);

  localparam logic [CW-1:0] CNT_ZERO  = '0;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_CYCLES - 1);
  // Only meaningful when STAGE_GAP >= 1; with a zero gap RELEASE is never entered.
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);

  localparam logic [SW-1:0] STAGE_ZERO = '0;
  localparam logic [SW-1:0] STAGE_ONE  = SW'(1);
  localparam logic [SW-1:0] STAGE_ALL  = SW'(N_CH);
  localparam logic [SW-1:0] STAGE_PRE  = SW'(N_CH - 1);

  localparam logic [N_CH-1:0] RSTN_NONE  = '0;
  localparam logic [N_CH-1:0] RSTN_ALL   = {N_CH{1'b1}};
  localparam logic [N_CH-1:0] RSTN_FIRST = N_CH'(1);

  // With no gap (or a single channel) the hold ends straight in DONE.
  localparam bit DIRECT_DONE = (STAGE_GAP == 0) || (N_CH == 1);

  logic w_lk;
  logic w_rq;
  logic w_abort;
  logic [N_CH-1:0] w_rstn_next;

  state_e            r_state;
  logic [CW-1:0]     r_cnt;
  logic [N_CH-1:0]   r_rstn;
  logic              r_rst_done;
  logic [SW-1:0]     r_stage;

  generate
    if (SYNC_IN != 0) begin : g_sync
      sync_2ff u_sync_lock (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_lock),
        .o_q   (w_lk)
      );
      sync_2ff u_sync_req (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rst_req),
        .o_q   (w_rq)
      );
    end else begin : g_direct
      assign w_lk = i_lock;
      assign w_rq = i_rst_req;
    end
  endgenerate

  // Lock loss and soft request are treated identically.
  assign w_abort = !w_lk || w_rq;

  // Outputs form a thermometer code, so releasing the next channel is a
  // left shift with a 1 filled in at the bottom.
  assign w_rstn_next = N_CH'({r_rstn, 1'b1});

  // Sequencer FSM with registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_HOLD;
      r_cnt      <= CNT_ZERO;
      r_rstn     <= RSTN_NONE;
      r_rst_done <= 1'b0;
      r_stage    <= STAGE_ZERO;
    end else begin
      case (r_state)
        ST_HOLD: begin
          r_rstn     <= RSTN_NONE;
          r_rst_done <= 1'b0;
          r_stage    <= STAGE_ZERO;
          if (w_abort) begin
            // Hold restarts from zero rather than pausing.
            r_cnt <= CNT_ZERO;
          end else if (r_cnt == HOLD_LAST) begin
            r_cnt <= CNT_ZERO;
            if (DIRECT_DONE) begin
              r_state    <= ST_DONE;
              r_rstn     <= RSTN_ALL;
              r_rst_done <= 1'b1;
              r_stage    <= STAGE_ALL;
            end else begin
              r_state <= ST_RELEASE;
              r_rstn  <= RSTN_FIRST;
              r_stage <= STAGE_ONE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        ST_RELEASE: begin
          if (w_abort) begin
            // Abort wins over a release due on the same edge.
            r_state    <= ST_HOLD;
            r_cnt      <= CNT_ZERO;
            r_rstn     <= RSTN_NONE;
            r_rst_done <= 1'b0;
            r_stage    <= STAGE_ZERO;
          end else if (r_cnt == GAP_LAST) begin
            r_cnt   <= CNT_ZERO;
            r_rstn  <= w_rstn_next;
            r_stage <= r_stage + STAGE_ONE;
            if (r_stage == STAGE_PRE) begin
              r_state    <= ST_DONE;
              r_rst_done <= 1'b1;
            end else begin
              r_state    <= ST_RELEASE;
              r_rst_done <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        ST_DONE: begin
          if (w_abort) begin
            r_state    <= ST_HOLD;
            r_cnt      <= CNT_ZERO;
            r_rstn     <= RSTN_NONE;
            r_rst_done <= 1'b0;
            r_stage    <= STAGE_ZERO;
          end else begin
            r_cnt      <= CNT_ZERO;
            r_rstn     <= RSTN_ALL;
            r_rst_done <= 1'b1;
            r_stage    <= STAGE_ALL;
          end
        end

        default: begin
          r_state    <= ST_HOLD;
          r_cnt      <= CNT_ZERO;
          r_rstn     <= RSTN_NONE;
          r_rst_done <= 1'b0;
          r_stage    <= STAGE_ZERO;
        end
      endcase
    end
  end

  assign o_rstn     = r_rstn;
  assign o_rst_done = r_rst_done;
  assign o_stage    = r_stage;

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq. Four instances share the stimulus:
//   A: RESET_CYCLES=10 STAGE_GAP=5 N_CH=4 SYNC_IN=0 (main sequence)
//   B: RESET_CYCLES=10 STAGE_GAP=0 N_CH=4 SYNC_IN=0 (all channels together)
//   C: RESET_CYCLES=1  STAGE_GAP=5 N_CH=1 SYNC_IN=0 (single channel)
//   D: RESET_CYCLES=10 STAGE_GAP=5 N_CH=4 SYNC_IN=1 (two-cycle input delay)
module tb_reset_seq;

  logic clk;
  logic rst;
  logic lock;
  logic req;

  logic [3:0] a_rstn, b_rstn, d_rstn;
  logic [0:0] c_rstn;
  logic       a_done, b_done, c_done, d_done;
  logic [2:0] a_stage, b_stage, d_stage;
  logic [0:0] c_stage;

  int checks;
  int errors;
  logic mon_en;

  reset_seq #(.RESET_CYCLES(10), .STAGE_GAP(5), .N_CH(4), .SYNC_IN(0)) u_a (
    .i_clk(clk), .i_rst(rst), .i_lock(lock), .i_rst_req(req),
    .o_rstn(a_rstn), .o_rst_done(a_done), .o_stage(a_stage));

  reset_seq #(.RESET_CYCLES(10), .STAGE_GAP(0), .N_CH(4), .SYNC_IN(0)) u_b (
    .i_clk(clk), .i_rst(rst), .i_lock(lock), .i_rst_req(req),
    .o_rstn(b_rstn), .o_rst_done(b_done), .o_stage(b_stage));

  reset_seq #(.RESET_CYCLES(1), .STAGE_GAP(5), .N_CH(1), .SYNC_IN(0)) u_c (
    .i_clk(clk), .i_rst(rst), .i_lock(lock), .i_rst_req(req),
    .o_rstn(c_rstn), .o_rst_done(c_done), .o_stage(c_stage));

  reset_seq #(.RESET_CYCLES(10), .STAGE_GAP(5), .N_CH(4), .SYNC_IN(1)) u_d (
    .i_clk(clk), .i_rst(rst), .i_lock(lock), .i_rst_req(req),
    .o_rstn(d_rstn), .o_rst_done(d_done), .o_stage(d_stage));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [3:0] rstn, input logic [2:0] stage, input logic done);
    check({tag, "_a_rstn"},  a_rstn,  rstn);
    check({tag, "_a_stage"}, a_stage, stage);
    check({tag, "_a_done"},  a_done,  done);
  endtask

  // Ordering invariants on A and D every cycle: thermometer code,
  // stage equals count of released channels, done iff all released.
  always @(negedge clk) begin
    if (mon_en) begin
      check("mono_a",  32'((a_rstn & (a_rstn + 4'd1)) == 4'd0), 32'd1);
      check("cnt_a",   32'(a_stage), 32'($countones(a_rstn)));
      check("done_a",  32'(a_done),  32'(a_rstn == 4'hF));
      check("mono_d",  32'((d_rstn & (d_rstn + 4'd1)) == 4'd0), 32'd1);
      check("cnt_d",   32'(d_stage), 32'($countones(d_rstn)));
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    rst  = 1'b1;
    lock = 1'b1;
    req  = 1'b0;

    // Reset state
    step(2);
    chk_a("rst", 4'h0, 3'd0, 1'b0);
    check("rst_b_rstn", b_rstn, 4'h0);
    check("rst_c_rstn", c_rstn, 1'b0);
    check("rst_c_done", c_done, 1'b0);
    check("rst_d_rstn", d_rstn, 4'h0);
    check("rst_d_stage", d_stage, 3'd0);
    mon_en = 1'b1;

    // Basic sequence
    rst = 1'b0;
    step(1);                                   // edge 1
    check("e1_c_rstn",  c_rstn,  1'b1);
    check("e1_c_done",  c_done,  1'b1);
    check("e1_c_stage", c_stage, 1'b1);
    chk_a("e1", 4'h0, 3'd0, 1'b0);
    step(8);                                   // edge 9
    chk_a("e9", 4'h0, 3'd0, 1'b0);
    check("e9_b_rstn", b_rstn, 4'h0);
    step(1);                                   // edge 10
    chk_a("e10", 4'h1, 3'd1, 1'b0);
    check("e10_b_rstn",  b_rstn,  4'hF);
    check("e10_b_done",  b_done,  1'b1);
    check("e10_b_stage", b_stage, 3'd4);
    step(1);                                   // edge 11
    check("e11_d_rstn", d_rstn, 4'h0);
    step(1);                                   // edge 12
    check("e12_d_rstn", d_rstn, 4'h1);
    step(2);                                   // edge 14
    chk_a("e14", 4'h1, 3'd1, 1'b0);
    step(1);                                   // edge 15
    chk_a("e15", 4'h3, 3'd2, 1'b0);
    step(5);                                   // edge 20
    chk_a("e20", 4'h7, 3'd3, 1'b0);
    step(5);                                   // edge 25
    chk_a("e25", 4'hF, 3'd4, 1'b1);
    step(2);                                   // edge 27
    check("e27_d_rstn", d_rstn, 4'hF);
    check("e27_d_done", d_done, 1'b1);

    // Soft reset from DONE, 3-cycle pulse
    req = 1'b1;
    step(1);                                   // R1
    chk_a("r1", 4'h0, 3'd0, 1'b0);
    check("r1_c_rstn", c_rstn, 1'b0);
    check("r1_d_rstn", d_rstn, 4'hF);
    step(1);                                   // R2
    check("r2_d_rstn", d_rstn, 4'hF);
    step(1);                                   // R3
    check("r3_d_rstn", d_rstn, 4'h0);
    chk_a("r3", 4'h0, 3'd0, 1'b0);
    req = 1'b0;
    step(1);                                   // F1
    check("f1_c_rstn", c_rstn, 1'b1);
    step(8);                                   // F9
    chk_a("f9", 4'h0, 3'd0, 1'b0);
    step(1);                                   // F10
    chk_a("f10", 4'h1, 3'd1, 1'b0);
    check("f10_b_rstn", b_rstn, 4'hF);
    step(1);                                   // F11
    check("f11_d_rstn", d_rstn, 4'h0);
    step(1);                                   // F12
    check("f12_d_rstn", d_rstn, 4'h1);

    // Abort on the edge bit 2 is due
    step(7);                                   // F19
    chk_a("f19", 4'h3, 3'd2, 1'b0);
    lock = 1'b0;
    step(1);                                   // F20
    chk_a("abort", 4'h0, 3'd0, 1'b0);

    // Lock gating: 20 edges low, then a one-edge glitch at hold count 7
    step(19);                                  // F39
    chk_a("lklow", 4'h0, 3'd0, 1'b0);
    check("lklow_b_rstn", b_rstn, 4'h0);
    lock = 1'b1;
    step(7);                                   // L7
    chk_a("l7", 4'h0, 3'd0, 1'b0);
    lock = 1'b0;
    step(1);                                   // L8
    lock = 1'b1;
    step(2);                                   // L10
    chk_a("l10", 4'h0, 3'd0, 1'b0);
    step(7);                                   // L17
    chk_a("l17", 4'h0, 3'd0, 1'b0);
    step(1);                                   // L18
    chk_a("l18", 4'h1, 3'd1, 1'b0);

    // Sequencer reset at stage 3
    step(10);                                  // L28
    chk_a("l28", 4'h7, 3'd3, 1'b0);
    rst = 1'b1;
    step(1);
    chk_a("srst1", 4'h0, 3'd0, 1'b0);
    step(2);
    chk_a("srst3", 4'h0, 3'd0, 1'b0);
    rst = 1'b0;
    step(9);
    chk_a("g9", 4'h0, 3'd0, 1'b0);
    step(1);
    chk_a("g10", 4'h1, 3'd1, 1'b0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_seq.md
Name: reset_seq

Overview:
- Parametrised power-on/soft reset sequencer; successor to the single-output power-on reset counter.
- Holds N_CH active-low reset outputs low for RESET_CYCLES after the clock source reports lock. Then releases them one by one, STAGE_GAP cycles apart, in index order: clock/PLL users first, then SCCB, capture, then VGA.
- Supports re-triggering from a soft-reset request and from loss of lock.
- Sits at top level directly behind the clock wizard; drives every downstream block's rstn.

Parameters:
- RESET_CYCLES, 100000, initial hold length in cycles after lock; legal range >= 1.
- STAGE_GAP, 1000, cycles between consecutive channel releases; 0 releases all channels together.
- N_CH, 4, number of reset output channels; legal range >= 1.
- SYNC_IN, 1, 1 = route i_lock and i_rst_req through a 2-flop synchroniser (+2 cycles latency); 0 = use them directly.

Ports:
- i_clk  input  1  single sequencer clock (free-running, e.g. 50 MHz board clock)
- i_rst  input  1  synchronous, active-high reset of the sequencer itself
- i_lock  input  1  clock source locked; low means all channels are held in reset
- i_rst_req  input  1  soft-reset request, level, active-high (button or register bit)
- o_rstn  output  N_CH  per-channel active-low reset; bit 0 is released first
- o_rst_done  output  1  high once every channel is released
- o_stage  output  $clog2(N_CH+1)  number of channels currently released

Behaviour:
- Reset and power-up initial values:
  - o_rstn = 0, o_rst_done = 0, o_stage = 0, state = HOLD, counter = 0.
  - i_rst takes effect on the clock edge, regardless of state.
- Inputs:
  - lk and rq denote i_lock and i_rst_req after optional synchronisation.
  - All decisions use lk/rq sampled at the same edge.
- Counter:
  - Width = $clog2(max(RESET_CYCLES, STAGE_GAP) + 1).
  - Never wraps: it is cleared on every state entry and on every abort.
- HOLD state:
  - o_rstn = 0, o_rst_done = 0.
  - At each edge where lk = 1 and rq = 0: counter += 1.
  - When counter == RESET_CYCLES-1 at such an edge: go to RELEASE, o_rstn[0] <= 1, o_stage <= 1, counter <= 0.
  - Result: o_rstn[0] is high after exactly RESET_CYCLES qualifying edges.
  - If lk = 0 or rq = 1: counter <= 0 and stay in HOLD. The hold restarts from zero and does not pause.
- RELEASE state (o_stage = k, with 1 <= k < N_CH):
  - Counter += 1 each edge.
  - When counter == STAGE_GAP-1: o_rstn[k] <= 1, o_stage <= k+1, counter <= 0.
  - If k+1 == N_CH: go to DONE and o_rst_done <= 1 on the same edge.
  - STAGE_GAP = 0: all remaining channels rise together with o_rstn[0]. HOLD goes directly to DONE; o_rst_done rises on the same edge as o_rstn[0].
  - N_CH = 1: HOLD goes directly to DONE.
- DONE state: outputs are static.
- Abort (RELEASE or DONE, at an edge sampling lk = 0 or rq = 1):
  - Next edge values: o_rstn = 0, o_rst_done = 0, o_stage = 0, counter = 0, state = HOLD.
  - All channels assert together (no reverse staging).
  - Abort takes priority over a release scheduled on the same edge.
- Simultaneous lk = 0 and rq = 1: same as abort; no distinction is made.
- rq held high: the sequence stays in HOLD with counter 0. The full RESET_CYCLES hold starts only after rq falls.
- Monotonic outputs: o_rstn bits only ever rise in index order. o_rstn[k] = 1 implies o_rstn[j] = 1 for all j < k.
- Outputs are registered: no combinational path from any input to any output.

Decomposition:
- Package reset_seq_pkg:
  - State encoding (HOLD, RELEASE, DONE).
  - Function clog2/max helper used for counter and o_stage widths.
- Sub-module sync_2ff:
  - Generic 2-flop synchroniser, one per async input.
  - Instantiated only when SYNC_IN = 1.
  - Reusable for the camera-side button inputs.

Test Plan:
- Basic sequence. RESET_CYCLES=10, STAGE_GAP=5, N_CH=4, SYNC_IN=0. Deassert i_rst with i_lock=1.
  -> o_rstn[0] rises 10 edges after i_rst falls; bits 1, 2, 3 follow at +5, +10, +15 edges.
  -> o_rst_done rises with bit 3; o_stage steps 1, 2, 3, 4.
- Lock gating. i_lock=0 for 20 cycles after reset, then 1.
  -> All o_rstn stay 0 until 10 edges after lock.
  -> A lock glitch low at hold count 7 restarts the count from 0 (total 10 more edges).
- Soft reset from DONE. Pulse i_rst_req for 3 cycles.
  -> Next edge: o_rstn = 4'b0000, o_rst_done = 0.
  -> Full sequence replays, o_rstn[0] rising 10 edges after i_rst_req falls.
- Abort mid-release. Drop i_lock when o_stage = 2, on the same edge that bit 2 is due.
  -> Bit 2 never rises; all outputs return to 0 the next edge.
- Corner parameters.
  -> STAGE_GAP=0: all 4 bits plus o_rst_done rise on the same edge.
  -> N_CH=1, RESET_CYCLES=1: o_rstn rises on the first qualifying edge.
  -> SYNC_IN=1: each response above is delayed by exactly 2 cycles.
- Sequencer reset mid-sequence. Assert i_rst at o_stage = 3.
  -> Outputs are 0 on that edge.
  -> Re-sequencing starts only after i_rst falls; monotonic ordering holds throughout.
